// File: rtl/xbar_pkg.sv
// Shared types and constants for the crossbar slave responder.
// Used by xbar_slave_responder and xbar_slv_regfile.
package xbar_pkg;

  localparam int XBAR_DW = 32;
  localparam int XBAR_AW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } xbar_slv_state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [31:0] XBAR_ERR_PATTERN = 32'hDEAD_BEEF;

  function automatic int xbar_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/xbar_slv_regfile.sv
// Local word store: DEPTH x DW flops, async active-low clear,
// one synchronous write port and one combinational read port.
module xbar_slv_regfile
  import xbar_pkg::*;
#(
  parameter int DW    = XBAR_DW,
  parameter int DEPTH = 16,
  parameter int IW    = xbar_idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/xbar_slave_responder.sv
// Crossbar slave endpoint: captures a request, waits LATENCY cycles, then acks.
// Optional out-of-range checking against BASE with macro XBAR_SLV_ERR_EN.
module xbar_slave_responder
  import xbar_pkg::*;
#(
  parameter int          DW      = XBAR_DW,
  parameter int          AW      = XBAR_AW,
  parameter int          DEPTH   = 16,
  parameter int          LATENCY = 2,
  parameter logic [AW-1:0] BASE  = 'h4000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rreq,
  input  logic [AW-1:0] aaddr,
  input  logic          ccmd,
  input  logic [DW-1:0] wwdata,
  output logic          aack,
  output logic [DW-1:0] rrdata,
`ifdef XBAR_SLV_ERR_EN
  output logic          err,
`endif
  output logic          busy
);

  localparam int         IW     = xbar_idx_w(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  xbar_slv_state_t state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;

  logic [IW-1:0]   cap_idx;
  logic            cap_cmd;
  logic [DW-1:0]   cap_wdata;

  logic            in_idle;
  logic            capture;
  logic            enter_ack;
  logic [IW-1:0]   cur_idx;
  logic            cur_cmd;
  logic [DW-1:0]   cur_wdata;
  logic            cur_oor;
  logic            mem_we;
  logic [DW-1:0]   mem_rdata;
  logic [DW-1:0]   rsp_data;

  // Next-state and wait counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (rreq) begin
          if (LATENCY == 0) begin
            state_nxt = ACK;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign in_idle   = (state == IDLE);
  assign capture   = in_idle && rreq;
  assign enter_ack = (state_nxt == ACK);

  // With LATENCY=0 ACK is entered on the capture edge, so the live inputs
  // must be used instead of the (not yet loaded) capture registers.
  assign cur_idx   = in_idle ? aaddr[2 +: IW] : cap_idx;
  assign cur_cmd   = in_idle ? ccmd           : cap_cmd;
  assign cur_wdata = in_idle ? wwdata         : cap_wdata;

`ifdef XBAR_SLV_ERR_EN
  localparam logic [AW-1:0] UPPER_MASK = {AW{1'b1}} << (2 + IW);

  logic live_oor;
  logic cap_oor;
  logic unused_addr_bits;

  assign live_oor         = |((aaddr ^ BASE) & UPPER_MASK);
  assign cur_oor          = in_idle ? live_oor : cap_oor;
  assign unused_addr_bits = ^aaddr[1:0];

  always_ff @(posedge clk) begin
    if (capture) begin
      cap_oor <= live_oor;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= enter_ack && cur_oor;
    end
  end
`else
  logic unused_addr_bits;

  assign cur_oor          = 1'b0;
  assign unused_addr_bits = ^{aaddr[1:0], aaddr[AW-1:2+IW], BASE};
`endif

  // Request capture: data path, no reset needed
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_idx   <= aaddr[2 +: IW];
      cap_cmd   <= ccmd;
      cap_wdata <= wwdata;
    end
  end

  assign mem_we = enter_ack && (cur_cmd == CMD_WRITE) && !cur_oor;

  xbar_slv_regfile #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .raddr (cur_idx),
    .rdata (mem_rdata)
  );

  always_comb begin
    rsp_data = mem_rdata;
    if (cur_oor) begin
      rsp_data = DW'(XBAR_ERR_PATTERN);
    end else if (cur_cmd == CMD_WRITE) begin
      rsp_data = cur_wdata;
    end
  end

  // Response register: loaded on ACK entry, held otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrdata <= '0;
    end else if (enter_ack) begin
      rrdata <= rsp_data;
    end
  end

  assign aack = (state == ACK);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_xbar_slave_responder.sv
// Directed bench for xbar_slave_responder: LATENCY=2 instance (dut) and
// LATENCY=0 instance (dut0); error cases selected by XBAR_SLV_ERR_EN.
module tb_xbar_slave_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rreq, rreq0;
  logic [31:0] aaddr;
  logic        ccmd;
  logic [31:0] wwdata;
  logic        aack, aack0, busy, busy0, err, err0;
  logic [31:0] rrdata, rrdata0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xbar_slave_responder #(.DW(32), .AW(32), .DEPTH(16), .LATENCY(2), .BASE(32'h4000_0000)) dut (
    .clk(clk), .reset(reset), .rreq(rreq), .aaddr(aaddr), .ccmd(ccmd), .wwdata(wwdata),
    .aack(aack), .rrdata(rrdata),
`ifdef XBAR_SLV_ERR_EN
    .err(err),
`endif
    .busy(busy));

  xbar_slave_responder #(.DW(32), .AW(32), .DEPTH(16), .LATENCY(0), .BASE(32'h4000_0000)) dut0 (
    .clk(clk), .reset(reset), .rreq(rreq0), .aaddr(aaddr), .ccmd(ccmd), .wwdata(wwdata),
    .aack(aack0), .rrdata(rrdata0),
`ifdef XBAR_SLV_ERR_EN
    .err(err0),
`endif
    .busy(busy0));

`ifndef XBAR_SLV_ERR_EN
  assign err  = 1'b0;
  assign err0 = 1'b0;
`endif

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One transaction on dut (sel=0) or dut0 (sel=1); returns at the negedge
  // after the ACK cycle, with the responder back in IDLE.
  task automatic txn(input int sel, input logic cmd, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd,
                     output int lat, output logic e);
    @(negedge clk);
    ccmd = cmd; aaddr = addr; wwdata = wd;
    if (sel == 0) rreq = 1'b1; else rreq0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rreq = 1'b0; rreq0 = 1'b0;
    lat = -1; rd = 'x; e = 1'bx;
    for (int j = 0; j < 8 && lat < 0; j++) begin
      if (j > 0) @(negedge clk);
      if ((sel == 0) ? aack : aack0) begin
        lat = j;
        rd  = (sel == 0) ? rrdata : rrdata0;
        e   = (sel == 0) ? err : err0;
      end
    end
    @(negedge clk);
    chk("ack_drop", (sel == 0) ? aack : aack0, 1'b0);
    chk("busy_drop", (sel == 0) ? busy : busy0, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        e;
    logic        saw_ack;

    reset = 1'b0; rreq = 1'b0; rreq0 = 1'b0;
    aaddr = '0; ccmd = 1'b0; wwdata = '0;

    // Fill the vector table
    tbl.push_back('{1'b1, 32'h4000_0004, 32'hA800_0000, 32'hA800_0000, 1'b0});
    tbl.push_back('{1'b0, 32'h4000_0004, 32'h0,         32'hA800_0000, 1'b0});
    tbl.push_back('{1'b0, 32'h4000_0007, 32'h0,         32'hA800_0000, 1'b0});
    tbl.push_back('{1'b0, 32'h4000_000C, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b1, 32'h4000_003C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b0, 32'h4000_003C, 32'h0,         32'hFFFF_FFFF, 1'b0});
`ifdef XBAR_SLV_ERR_EN
    tbl.push_back('{1'b1, 32'h8000_0000, 32'h0000_0077, 32'hDEAD_BEEF, 1'b1});
    tbl.push_back('{1'b0, 32'h4000_0000, 32'h0,         32'h0,         1'b0});
    tbl.push_back('{1'b1, 32'h0000_0008, 32'h0000_0005, 32'hDEAD_BEEF, 1'b1});
    tbl.push_back('{1'b0, 32'h4000_0008, 32'h0,         32'h0,         1'b0});
`else
    tbl.push_back('{1'b1, 32'h0000_0008, 32'h0000_0005, 32'h0000_0005, 1'b0});
    tbl.push_back('{1'b0, 32'h4000_0008, 32'h0,         32'h0000_0005, 1'b0});
    tbl.push_back('{1'b1, 32'h4000_0040, 32'h0000_1234, 32'h0000_1234, 1'b0});
    tbl.push_back('{1'b0, 32'h4000_0000, 32'h0,         32'h0000_1234, 1'b0});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_aack", aack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rrdata", rrdata, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_aack0", aack0, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven transactions on the LATENCY=2 instance
    foreach (tbl[i]) begin
      txn(0, tbl[i].cmd, tbl[i].addr, tbl[i].wdata, rd, lat, e);
      chk($sformatf("vec%0d_lat", i), lat, 2);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), e, tbl[i].exp_err);
    end

    // Hold: rrdata and aack stay put while idle
    txn(0, 1'b1, 32'h4000_0010, 32'h1, rd, lat, e);
    txn(0, 1'b0, 32'h4000_0010, 32'h0, rd, lat, e);
    chk("hold_first", rd, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_rdata%0d", i), rrdata, 32'h1);
      chk($sformatf("hold_aack%0d", i), aack, 1'b0);
    end

    // LATENCY=0: single write, then back-to-back reads with rreq held
    txn(1, 1'b1, 32'h4000_0004, 32'h0000_0011, rd, lat, e);
    chk("l0_lat", lat, 0);
    chk("l0_wr_echo", rd, 32'h11);
    ccmd = 1'b0; aaddr = 32'h4000_0004; rreq0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_aack%0d", i), aack0, (i % 2 == 0));
      chk($sformatf("b2b_busy%0d", i), busy0, (i % 2 == 0));
      if (i % 2 == 0) chk($sformatf("b2b_rdata%0d", i), rrdata0, 32'h11);
    end
    rreq0 = 1'b0;
    @(negedge clk);

    // Reset mid-WAIT discards the in-flight write and clears everything
    ccmd = 1'b1; aaddr = 32'h4000_0018; wwdata = 32'h9; rreq = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rreq = 1'b0;
    chk("mw_busy_before", busy, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mw_busy", busy, 1'b0);
    chk("mw_aack", aack, 1'b0);
    chk("mw_rrdata", rrdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    saw_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (aack) saw_ack = 1'b1;
    end
    chk("mw_no_ack", saw_ack, 1'b0);
    txn(0, 1'b0, 32'h4000_0018, 32'h0, rd, lat, e);
    chk("mw_discarded", rd, 32'h0);
    txn(0, 1'b0, 32'h4000_0004, 32'h0, rd, lat, e);
    chk("mw_mem_clear", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
